// File: rtl/pkt_put_consumer_if.sv
// Bundles the producer-side put handshake and the analysis-port outputs of pkt_put_consumer.
// Latency: none, wires only.
// Backpressure: in_ready throttles the put side; the ap_* strobe cannot be stalled.
interface pkt_put_consumer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_cmd;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        ap_valid;
    logic        ap_cmd;
    logic [31:0] ap_addr;
    logic [31:0] ap_data;
    logic [7:0]  ap_seq;

    // Producer / scoreboard side
    modport master (
        output in_valid, in_cmd, in_addr, in_data,
        input  in_ready, ap_valid, ap_cmd, ap_addr, ap_data, ap_seq
    );

    // Consumer block side
    modport slave (
        input  in_valid, in_cmd, in_addr, in_data,
        output in_ready, ap_valid, ap_cmd, ap_addr, ap_data, ap_seq
    );
endinterface

// File: rtl/pkt_put_consumer.sv
// Queues put packets in a DEPTH-entry FIFO, holds each for LAT cycles, then emits it on a one-cycle analysis strobe.
// Latency: accept on edge E into an idle block -> ap_valid in the cycle after edge E+LAT+1; throughput one packet per LAT+1 cycles.
// Backpressure: in_ready = FIFO not full (registered state only); the analysis strobe is never stalled.
module pkt_put_consumer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    pkt_put_consumer_if.slave        pkt_if,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [3:0]     LAT_L    = 4'(LAT);

    typedef enum logic [1:0] {IDLE, PROC, EMIT} state_t;

    typedef struct packed {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } pkt_t;

    pkt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    state_t        r_state;
    logic [3:0]    r_cnt;
    pkt_t          r_work;
    logic [7:0]    r_seq;
    logic          r_ap_valid;
    pkt_t          r_ap;
    logic [7:0]    r_ap_seq;

    wire w_ready = (r_level != LVL_FULL);
    wire w_push  = pkt_if.in_valid && w_ready;
    // IDLE and EMIT are the only states that take a new packet from the FIFO head.
    wire w_pop   = ((r_state == IDLE) || (r_state == EMIT)) && (r_level != '0);
    wire pkt_t w_in_pkt = '{cmd: pkt_if.in_cmd, addr: pkt_if.in_addr, data: pkt_if.in_data};

    // Packet storage; contents need no reset since level/pointers gate every read.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_pkt;
        end
    end

    // FIFO pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Processing FSM: pop -> count LAT cycles -> one-cycle emit, with registered analysis outputs.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_work     <= '0;
            r_seq      <= '0;
            r_ap_valid <= 1'b0;
            r_ap       <= '0;
            r_ap_seq   <= '0;
        end else begin
            r_ap_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_work  <= r_mem[r_rd_ptr];
                        r_cnt   <= LAT_L;
                        r_state <= PROC;
                    end
                end
                PROC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state    <= EMIT;
                        r_ap_valid <= 1'b1;
                        r_ap       <= r_work;
                        r_ap_seq   <= r_seq;
                    end
                end
                EMIT: begin
                    r_seq <= r_seq + 8'd1;
                    if (w_pop) begin
                        r_work  <= r_mem[r_rd_ptr];
                        r_cnt   <= LAT_L;
                        r_state <= PROC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pkt_if.in_ready = w_ready;
    assign pkt_if.ap_valid = r_ap_valid;
    assign pkt_if.ap_cmd   = r_ap.cmd;
    assign pkt_if.ap_addr  = r_ap.addr;
    assign pkt_if.ap_data  = r_ap.data;
    assign pkt_if.ap_seq   = r_ap_seq;
    assign fifo_level      = r_level;
    assign busy            = (r_state != IDLE) || (r_level != '0);
endmodule

// File: tb/tb_pkt_put_consumer.sv
// Bench for pkt_put_consumer: two instances (LAT=3 and LAT=1, DEPTH=4) against an edge-indexed timing model.
// Latency: n/a.
// Backpressure: drivers hold packets while in_ready is low.
module tb_pkt_put_consumer;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic        d_vld  [2];
    logic        d_cmd  [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_data [2];
    logic        o_rdy  [2];
    logic        o_vld  [2];
    logic        o_cmd  [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_data [2];
    logic [7:0]  o_seq  [2];
    logic [2:0]  o_lvl  [2];
    logic        o_busy [2];
    logic [2:0]  lvl0, lvl1;
    logic        busy0, busy1;

    pkt_put_consumer_if u_if0();
    pkt_put_consumer_if u_if1();

    assign u_if0.in_valid = d_vld[0];
    assign u_if0.in_cmd   = d_cmd[0];
    assign u_if0.in_addr  = d_addr[0];
    assign u_if0.in_data  = d_data[0];
    assign u_if1.in_valid = d_vld[1];
    assign u_if1.in_cmd   = d_cmd[1];
    assign u_if1.in_addr  = d_addr[1];
    assign u_if1.in_data  = d_data[1];

    assign o_rdy[0]  = u_if0.in_ready;  assign o_rdy[1]  = u_if1.in_ready;
    assign o_vld[0]  = u_if0.ap_valid;  assign o_vld[1]  = u_if1.ap_valid;
    assign o_cmd[0]  = u_if0.ap_cmd;    assign o_cmd[1]  = u_if1.ap_cmd;
    assign o_addr[0] = u_if0.ap_addr;   assign o_addr[1] = u_if1.ap_addr;
    assign o_data[0] = u_if0.ap_data;   assign o_data[1] = u_if1.ap_data;
    assign o_seq[0]  = u_if0.ap_seq;    assign o_seq[1]  = u_if1.ap_seq;
    assign o_lvl[0]  = lvl0;            assign o_lvl[1]  = lvl1;
    assign o_busy[0] = busy0;           assign o_busy[1] = busy1;

    pkt_put_consumer #(.DEPTH(DEPTH), .LAT(3)) u_dut0 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .pkt_if         (u_if0),
        .fifo_level     (lvl0),
        .busy           (busy0)
    );

    pkt_put_consumer #(.DEPTH(DEPTH), .LAT(1)) u_dut1 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .pkt_if         (u_if1),
        .fifo_level     (lvl1),
        .busy           (busy1)
    );

    // ---------------- reference model (edge-indexed schedule) ----------------
    typedef struct {
        int          pop;
        int          emit;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  seq;
    } exp_t;

    int   lat_of [2] = '{3, 1};
    exp_t svc_q  [2][$];
    exp_t exp_q  [2][$];
    exp_t last   [2];
    int   m_lvl  [2];
    int   m_seq  [2];
    int   last_emit [2];
    int   cur_emit  [2];
    int   t = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   saw_full  [2];
    bit   wrap_seen [2];
    int   prev_seq  [2];
    int   pulse_t   [2][$];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h (edge %0d)", nm, k, act, want, t);
        end
    endtask

    // Each accepted packet is popped one edge after max(accept edge, previous emit edge)
    // and emitted LAT edges after its pop.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                svc_q[k].delete();
                exp_q[k].delete();
                m_lvl[k]     = 0;
                m_seq[k]     = 0;
                last_emit[k] = -1000;
                cur_emit[k]  = -1000;
                last[k]      = '{pop: 0, emit: 0, cmd: 1'b0, addr: 32'd0, data: 32'd0, seq: 8'd0};
            end
        end else begin
            t = t + 1;
            for (int k = 0; k < 2; k++) begin
                bit   acc;
                exp_t e;
                acc = d_vld[k] && (m_lvl[k] != DEPTH);
                if (svc_q[k].size() > 0 && svc_q[k][0].pop == t) begin
                    cur_emit[k] = svc_q[k][0].emit;
                    void'(svc_q[k].pop_front());
                    m_lvl[k]--;
                end
                if (acc) begin
                    e.pop  = ((t > last_emit[k]) ? t : last_emit[k]) + 1;
                    e.emit = e.pop + lat_of[k];
                    e.cmd  = d_cmd[k];
                    e.addr = d_addr[k];
                    e.data = d_data[k];
                    e.seq  = 8'(m_seq[k]);
                    m_seq[k]     = (m_seq[k] + 1) % 256;
                    last_emit[k] = e.emit;
                    svc_q[k].push_back(e);
                    exp_q[k].push_back(e);
                    m_lvl[k]++;
                end
            end
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = 1'b0;
            if (exp_q[k].size() > 0 && exp_q[k][0].emit == t) begin
                ev      = 1'b1;
                last[k] = exp_q[k].pop_front();
            end
            chk("ap_valid",   k, 32'(o_vld[k]),  32'(ev));
            chk("ap_cmd",     k, 32'(o_cmd[k]),  32'(last[k].cmd));
            chk("ap_addr",    k, o_addr[k],      last[k].addr);
            chk("ap_data",    k, o_data[k],      last[k].data);
            chk("ap_seq",     k, 32'(o_seq[k]),  32'(last[k].seq));
            chk("in_ready",   k, 32'(o_rdy[k]),  32'(m_lvl[k] != DEPTH));
            chk("fifo_level", k, 32'(o_lvl[k]),  32'(m_lvl[k]));
            chk("busy",       k, 32'(o_busy[k]), 32'((m_lvl[k] > 0) || (cur_emit[k] >= t)));
            if (o_vld[k] === 1'b1) begin
                if (prev_seq[k] == 255 && o_seq[k] == 8'd0) wrap_seen[k] = 1'b1;
                prev_seq[k] = int'(o_seq[k]);
                pulse_t[k].push_back(t);
            end
            if (o_lvl[k] == 3'(DEPTH) && o_rdy[k] === 1'b0) saw_full[k] = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int k, input logic c, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        bit r;
        @(negedge clk);
        d_vld[k] = 1'b1; d_cmd[k] = c; d_addr[k] = a; d_data[k] = d;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            r = o_rdy[k];
            @(posedge clk);
            if (r) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("accept_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        d_vld[k] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = !o_busy[0] && !o_busy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        chk("drain_timeout", 0, 32'(done), 32'd1);
    endtask

    task automatic burst(input int k);
        for (int i = 0; i < 8; i++) send(k, 1'(i), 32'h100 + 32'(i), 32'(i));
        idle(k);
    endtask

    task automatic rand_stream(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(k);
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            send(k, 1'($urandom), $urandom, $urandom);
        end
        idle(k);
    endtask

    initial begin
        int first [2];
        int npulse [2];
        int bad;
        bit got;

        for (int k = 0; k < 2; k++) begin
            d_vld[k] = 1'b0; d_cmd[k] = 1'b0; d_addr[k] = '0; d_data[k] = '0;
            prev_seq[k] = -1;
        end

        // Reset values hold without any clock edge.
        #2 rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ap_valid",   k, 32'(o_vld[k]),  32'd0);
            chk("rst_in_ready",   k, 32'(o_rdy[k]),  32'd1);
            chk("rst_fifo_level", k, 32'(o_lvl[k]),  32'd0);
            chk("rst_busy",       k, 32'(o_busy[k]), 32'd0);
            chk("rst_ap_seq",     k, 32'(o_seq[k]),  32'd0);
            chk("rst_ap_addr",    k, o_addr[k],      32'd0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Single packet into an idle block: fixed latency and fields.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            d_vld[k] = 1'b1; d_cmd[k] = 1'b1; d_addr[k] = 32'h1000; d_data[k] = 32'hDEADBEEF;
        end
        @(posedge clk);
        @(negedge clk);
        d_vld[0] = 1'b0; d_vld[1] = 1'b0;
        first  = '{-1, -1};
        npulse = '{0, 0};
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (o_vld[k] === 1'b1) begin
                    npulse[k]++;
                    if (first[k] < 0) begin
                        first[k] = i;
                        chk("lat_cmd",  k, 32'(o_cmd[k]), 32'd1);
                        chk("lat_addr", k, o_addr[k],     32'h1000);
                        chk("lat_data", k, o_data[k],     32'hDEADBEEF);
                        chk("lat_seq",  k, 32'(o_seq[k]), 32'd0);
                    end
                end
            end
        end
        chk("lat_first_edge", 0, 32'(first[0]), 32'd4);
        chk("lat_first_edge", 1, 32'(first[1]), 32'd2);
        chk("lat_pulses",     0, 32'(npulse[0]), 32'd1);
        chk("lat_pulses",     1, 32'(npulse[1]), 32'd1);
        drain();

        // Held-valid burst of 8: FIFO fills, pulses spaced LAT+1 apart.
        pulse_t[0].delete(); pulse_t[1].delete();
        saw_full = '{1'b0, 1'b0};
        fork
            burst(0);
            burst(1);
        join
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("burst_full_seen", k, 32'(saw_full[k]), 32'd1);
            chk("burst_pulses",    k, 32'(pulse_t[k].size()), 32'd8);
            bad = 0;
            for (int i = 1; i < pulse_t[k].size(); i++)
                if (pulse_t[k][i] - pulse_t[k][i-1] != ((k == 0) ? 4 : 2)) bad++;
            chk("burst_spacing", k, 32'(bad), 32'd0);
        end

        // Random traffic long enough to wrap the sequence tag.
        fork
            rand_stream(0, 260);
            rand_stream(1, 260);
        join
        drain();
        chk("seq_wrap", 0, 32'(wrap_seen[0]), 32'd1);
        chk("seq_wrap", 1, 32'(wrap_seen[1]), 32'd1);

        // Reset during PROC with three packets queued.
        for (int i = 0; i < 4; i++) send(0, 1'b0, 32'h2000 + 32'(i), 32'(i));
        #1;
        chk("pre_rst_level", 0, 32'(o_lvl[0]),  32'd3);
        chk("pre_rst_busy",  0, 32'(o_busy[0]), 32'd1);
        #1 rstn = 1'b0;
        d_vld[0] = 1'b0;
        #1;
        chk("mid_rst_ap_valid",   0, 32'(o_vld[0]), 32'd0);
        chk("mid_rst_fifo_level", 0, 32'(o_lvl[0]), 32'd0);
        chk("mid_rst_in_ready",   0, 32'(o_rdy[0]), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        send(0, 1'b1, 32'hA5A5, 32'h5A5A);
        idle(0);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (o_vld[0] === 1'b1) begin
                got = 1'b1;
                chk("post_rst_seq",  0, 32'(o_seq[0]), 32'd0);
                chk("post_rst_addr", 0, o_addr[0],     32'hA5A5);
            end
        end
        chk("post_rst_emit", 0, 32'(got), 32'd1);
        drain();
        chk("leftover_expect", 0, 32'(exp_q[0].size()), 32'd0);
        chk("leftover_expect", 1, 32'(exp_q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pkt_put_consumer.md
PKT_PUT_CONSUMER -- requirements
Module: pkt_put_consumer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, which sets the packet FIFO depth; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL provide parameter LAT, default 3, which sets the processing cycles per packet; legal values are 1 to 15.
REQ-003 nvdla_core_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream producer offers a packet (blocking-put request).
REQ-006 in_ready  output  1  block can accept a packet this cycle.
REQ-007 in_cmd  input  1  packet command (0=read, 1=write).
REQ-008 in_addr  input  32  packet address.
REQ-009 in_data  input  32  packet data.
REQ-010 ap_valid  output  1  one-cycle analysis write strobe to the downstream scoreboard; the downstream side cannot back-pressure it.
REQ-011 ap_cmd  output  1  emitted packet command.
REQ-012 ap_addr  output  32  emitted packet address.
REQ-013 ap_data  output  32  emitted packet data.
REQ-014 ap_seq  output  8  emitted-packet sequence tag.
REQ-015 fifo_level  output  $clog2(DEPTH)+1  number of queued packets.
REQ-016 busy  output  1  high when the state machine is not IDLE or fifo_level is nonzero.

Function
REQ-017 A packet SHALL be accepted on a rising edge where in_valid and in_ready are both 1, and written to the FIFO tail on that edge.
REQ-018 in_ready SHALL equal (fifo_level != DEPTH) and SHALL be a function of registered state only, with no combinational path from in_valid.
REQ-019 Upstream SHALL hold in_cmd, in_addr and in_data stable while in_valid=1 and in_ready=0; the block SHALL NOT sample the inputs in those cycles.
REQ-020 The state machine SHALL have the states IDLE, PROC and EMIT.
REQ-021 IDLE with fifo_level>0: pop the FIFO head into the working register, load the counter with LAT, and go to PROC.
REQ-022 IDLE with fifo_level=0: stay in IDLE.
REQ-023 PROC: decrement the counter each cycle; on the edge where the counter equals 1, go to EMIT.
REQ-024 EMIT SHALL drive ap_valid=1 for exactly one cycle, with ap_cmd, ap_addr and ap_data equal to the working register and ap_seq equal to the sequence counter.
REQ-025 On leaving EMIT, the sequence counter SHALL increment modulo 256 (255 wraps to 0).
REQ-026 From EMIT, if fifo_level>0 the block SHALL pop the next packet and go directly to PROC (back-to-back); otherwise it SHALL go to IDLE.
REQ-027 Latency: a packet accepted on edge E into an empty, idle block SHALL produce ap_valid in the cycle following edge E+LAT+1.
REQ-028 Sustained throughput SHALL be one packet per LAT+1 cycles.
REQ-029 Packets SHALL be emitted in acceptance order, without loss or duplication, while reset is deasserted.
REQ-030 A push and a pop on the same edge SHALL leave fifo_level unchanged.
REQ-031 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-032 fifo_level SHALL count from 0 to DEPTH and SHALL never exceed DEPTH.
REQ-033 ap_cmd, ap_addr, ap_data and ap_seq SHALL hold their last emitted values while ap_valid=0.

Reset
REQ-034 While nvdla_core_rstn=0, the outputs SHALL be held at these values, independent of the clock:
- state=IDLE, ap_valid=0, ap_cmd=0, ap_addr=0, ap_data=0
- ap_seq=0, sequence counter=0, fifo_level=0
- FIFO read and write pointers=0, busy=0
- in_ready=1
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-process packets; no ap_valid SHALL appear for those packets after reset is released.
REQ-036 The first edge after reset release SHALL be able to accept a packet.

Verification
REQ-037 LAT=3, idle block: accept {cmd=1, addr=0x1000, data=0xDEADBEEF} on edge 10 -> ap_valid high only in the cycle after edge 14, with those fields and ap_seq=0.
REQ-038 DEPTH=4, in_valid held at 1 for 8 packets with data 0..7 -> in_ready drops when fifo_level=4; all 8 emitted in order with ap_valid pulses spaced 4 cycles apart and ap_seq 0..7.
REQ-039 Stall: in_valid=1 and in_ready=0 for 5 cycles with the inputs held -> exactly one acceptance, when in_ready rises.
REQ-040 Sequence wrap: 257 packets -> the last two emitted packets carry ap_seq=255 and ap_seq=0.
REQ-041 Reset asserted during PROC with 3 packets queued -> ap_valid=0, fifo_level=0 and in_ready=1 immediately (asynchronous); no stale emission after release; the next packet emits with ap_seq=0.
REQ-042 LAT=1 back-to-back: 3 packets -> ap_valid pulses every 2 cycles, with fifo_level consistent on the simultaneous push/pop edges.
